// File: rtl/inference_pkg.sv
// Shared constants and types for the inference front end: frame geometry,
// framing byte and the frame loader state encoding.
package inference_pkg;

   localparam int unsigned NUM_PIXELS   = 784;
   localparam int unsigned PIXEL_ADDR_W = 10;
   localparam logic [7:0]  SYNC_BYTE    = 8'hAA;
   localparam int unsigned PIXEL_SHIFT  = 1;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_RECV = 2'd1,
      LD_FULL = 2'd2
   } loader_state_e;

endpackage

// File: rtl/pixel_pingpong_ram.sv
// Two-bank pixel buffer: one write port and one registered read port, each with
// its own bank select. Out-of-range read addresses return zero.
module pixel_pingpong_ram
   import inference_pkg::*;
#(
   parameter int unsigned DEPTH  = NUM_PIXELS,
   parameter int unsigned ADDR_W = PIXEL_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0]        mem [2][DEPTH];
   logic [7:0]        rd_raw_q;
   logic              rd_ok_d, rd_ok_q;
   logic [ADDR_W-1:0] rd_idx;

   // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
   always_comb begin
      rd_ok_d = 1'b0;
      rd_idx  = '0;
      if (rd_addr < ADDR_W'(DEPTH)) begin
         rd_ok_d = 1'b1;
         rd_idx  = rd_addr;
      end
   end

   // NOTE: the array and its read register carry no reset so the tools can map them onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
      rd_raw_q <= mem[rd_bank][rd_idx];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ok_q <= 1'b0;
      end else begin
         rd_ok_q <= rd_ok_d;
      end
   end

   assign rd_data = rd_ok_q ? rd_raw_q : 8'h00;

endmodule

// File: rtl/image_frame_loader.sv
// Receives sync-framed pixel bytes into the write bank of a ping-pong buffer and
// hands each complete frame to the inference core, one frame in flight at a time.
module image_frame_loader
   import inference_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned ADDR_W         = PIXEL_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              weights_ready,
   input  logic              inference_done,
   input  logic [ADDR_W-1:0] input_addr,
   output logic [7:0]        input_pixel,
   output logic              start_inference,
   output logic              frame_error,
   output logic              overrun,
   output logic              busy_loading
);

   localparam int unsigned       TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   loader_state_e     state_q, state_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              in_flight_q, in_flight_d;
   logic              start_q, start_d;
   logic              frame_error_q, frame_error_d;
   logic              overrun_q, overrun_d;
   logic              wr_en;
   logic              is_sync;
   logic              commit;

   assign is_sync = rx_valid && (rx_data == SYNC_BYTE);
   // Uses the registered in_flight, so a same-cycle inference_done delays the commit by one cycle.
   assign commit  = (state_q == LD_FULL) && !in_flight_q && weights_ready;

   always_comb begin
      state_d       = state_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      wr_addr_d     = wr_addr_q;
      tmo_d         = tmo_q;
      in_flight_d   = in_flight_q;
      start_d       = 1'b0;
      frame_error_d = 1'b0;
      overrun_d     = overrun_q;
      wr_en         = 1'b0;

      if (inference_done) begin
         in_flight_d = 1'b0;
      end

      unique case (state_q)
         LD_IDLE: begin
            if (is_sync) begin
               state_d   = LD_RECV;
               wr_addr_d = '0;
               tmo_d     = '0;
            end
         end
         LD_RECV: begin
            if (rx_valid) begin
               wr_en = 1'b1;
               tmo_d = '0;
               if (wr_addr_q == LAST_ADDR) begin
                  state_d = LD_FULL;
               end else begin
                  wr_addr_d = wr_addr_q + 1'b1;
               end
            end else if (tmo_q == TMO_LAST) begin
               frame_error_d = 1'b1;
               wr_addr_d     = '0;
               state_d       = LD_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         LD_FULL: begin
            if (is_sync) begin
               overrun_d = 1'b1;
            end
            if (commit) begin
               wr_bank_d   = rd_bank_q;
               rd_bank_d   = wr_bank_q;
               start_d     = 1'b1;
               in_flight_d = 1'b1;
               state_d     = LD_IDLE;
            end
         end
         default: state_d = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= LD_IDLE;
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b1;
         wr_addr_q     <= '0;
         tmo_q         <= '0;
         in_flight_q   <= 1'b0;
         start_q       <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         wr_addr_q     <= wr_addr_d;
         tmo_q         <= tmo_d;
         in_flight_q   <= in_flight_d;
         start_q       <= start_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
      end
   end

   pixel_pingpong_ram #(
      .DEPTH  (NUM_PIXELS),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_bank (wr_bank_q),
      .wr_addr (wr_addr_q),
      .wr_data (rx_data >> PIXEL_SHIFT),
      .rd_bank (rd_bank_q),
      .rd_addr (input_addr),
      .rd_data (input_pixel)
   );

   assign start_inference = start_q;
   assign frame_error     = frame_error_q;
   assign overrun         = overrun_q;
   assign busy_loading    = (state_q == LD_RECV);

endmodule

// File: tb/tb_image_frame_loader.sv
// Directed bench for image_frame_loader: frame load, ping-pong hold-off, timeout,
// weights gating, overrun with coincident done, and mid-frame reset.
module tb_image_frame_loader;

   localparam int unsigned TMO = 300;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       weights_ready = 1'b0;
   logic       inference_done = 1'b0;
   logic [9:0] input_addr = '0;
   logic [7:0] input_pixel;
   logic       start_inference;
   logic       frame_error;
   logic       overrun;
   logic       busy_loading;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int ferr_cnt = 0;

   always #5 clk = ~clk;

   image_frame_loader #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk             (clk),
      .rst             (rst),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .weights_ready   (weights_ready),
      .inference_done  (inference_done),
      .input_addr      (input_addr),
      .input_pixel     (input_pixel),
      .start_inference (start_inference),
      .frame_error     (frame_error),
      .overrun         (overrun),
      .busy_loading    (busy_loading)
   );

   always @(negedge clk) begin
      if (start_inference === 1'b1) start_cnt++;
      if (frame_error === 1'b1) ferr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] fill, input bit ramp);
      send_byte(8'hAA);
      for (int i = 0; i < 784; i++) begin
         send_byte(ramp ? i[7:0] : fill);
      end
   endtask

   task automatic read_check(input string tag, input int addr, input logic [7:0] exp);
      input_addr = addr[9:0];
      tick();
      check(tag, input_pixel, exp);
   endtask

   task automatic pulse_done();
      inference_done = 1'b1;
      tick();
      inference_done = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_pix"}, input_pixel, 0);
      check({tag, "_start"}, start_inference, 0);
      check({tag, "_ferr"}, frame_error, 0);
      check({tag, "_ovr"}, overrun, 0);
      check({tag, "_busy"}, busy_loading, 0);
   endtask

   initial begin
      int s0;
      // Reset state
      repeat (3) tick();
      check_idle_outputs("rst");
      rst = 1'b0;
      weights_ready = 1'b1;

      // 1: all-0xFE frame -> 0x7F, start two cycles after last byte
      send_byte(8'hAA);
      check("t1_busy", busy_loading, 1);
      for (int i = 0; i < 784; i++) send_byte(8'hFE);
      check("t1_start_early", start_inference, 0);
      tick();
      check("t1_start", start_inference, 1);
      tick();
      check("t1_start_pulse", start_inference, 0);
      check("t1_start_cnt", start_cnt, 1);
      read_check("t1_rd0", 0, 8'h7F);
      read_check("t1_rd391", 391, 8'h7F);
      read_check("t1_rd783", 783, 8'h7F);
      read_check("t1_rd784", 784, 8'h00);
      read_check("t1_rd1023", 1023, 8'h00);

      // 2: frame A committed, frame B held while A is in flight
      pulse_done();
      send_frame(8'h00, 1'b1);
      repeat (2) tick();
      check("t2_start_a", start_cnt, 2);
      read_check("t2_a200", 200, 8'd100);
      read_check("t2_a255", 255, 8'd127);
      read_check("t2_a256", 256, 8'd0);
      read_check("t2_a783", 783, 8'd7);
      send_frame(8'h00, 1'b0);
      repeat (5) tick();
      check("t2_no_start_b", start_cnt, 2);
      read_check("t2_still_a", 200, 8'd100);
      pulse_done();
      check("t2_start_wait", start_inference, 0);
      tick();
      check("t2_start_b", start_inference, 1);
      read_check("t2_b200", 200, 8'd0);

      // 3: timeout inside a frame
      pulse_done();
      send_byte(8'hAA);
      for (int i = 0; i < 100; i++) send_byte(8'h33);
      repeat (TMO - 1) tick();
      check("t3_no_err_yet", frame_error, 0);
      check("t3_busy_yet", busy_loading, 1);
      tick();
      check("t3_err", frame_error, 1);
      check("t3_busy_off", busy_loading, 0);
      tick();
      check("t3_err_pulse", frame_error, 0);
      check("t3_no_start", start_cnt, 3);
      send_frame(8'h10, 1'b0);
      repeat (2) tick();
      check("t3_recover_start", start_cnt, 4);
      read_check("t3_rd5", 5, 8'h08);

      // 4: weights_ready gates the commit
      pulse_done();
      weights_ready = 1'b0;
      send_frame(8'h40, 1'b0);
      repeat (5) tick();
      check("t4_gated", start_cnt, 4);
      read_check("t4_old", 5, 8'h08);
      weights_ready = 1'b1;
      tick();
      check("t4_start", start_inference, 1);
      read_check("t4_new", 700, 8'h20);

      // 5: overrun while held, then done coincides with the commit condition
      send_frame(8'h06, 1'b0);
      repeat (3) tick();
      check("t5_ovr_before", overrun, 0);
      send_byte(8'hAA);
      check("t5_ovr", overrun, 1);
      check("t5_not_busy", busy_loading, 0);
      s0 = start_cnt;
      pulse_done();
      check("t5_start_wait", start_inference, 0);
      tick();
      check("t5_start", start_inference, 1);
      tick();
      check("t5_one_start", start_cnt, s0 + 1);
      check("t5_ovr_sticky", overrun, 1);
      read_check("t5_rd", 10, 8'h03);

      // 6: reset mid-frame, then a fresh frame from address 0
      pulse_done();
      send_byte(8'hAA);
      for (int i = 0; i < 400; i++) send_byte(8'h22);
      rst = 1'b1;
      tick();
      check_idle_outputs("t6_rst");
      rst = 1'b0;
      s0 = start_cnt;
      send_byte(8'hAA);
      send_byte(8'hC8);
      for (int i = 1; i < 784; i++) send_byte(8'h50);
      repeat (2) tick();
      check("t6_start", start_cnt, s0 + 1);
      read_check("t6_rd0", 0, 8'h64);
      read_check("t6_rd1", 1, 8'h28);
      read_check("t6_rd783", 783, 8'h28);
      check("t6_ferr_total", ferr_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
